// File: rtl/video_wr_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : video_wr_burst_ctrl
// Purpose  : Turns 256-bit prefetch-FIFO words into fixed-length AXI INCR write
//            bursts over a ring of frame buffers. Option macro:
//            VIDEO_WR_BRESP_CHK_EN (sticky axi_err on non-OKAY bresp).
// Revision : 1.0 - initial release
// ============================================================================
module video_wr_burst_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] FRAME_BYTES = 32'h007E_9000,
  parameter int          FRAME_NUM   = 3,
  parameter int          BURST_LEN   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_start,
  input  logic [8:0]   fifo_rd_cnt,
  input  logic         fifo_rd_vld,
  input  logic [255:0] fifo_rd_data,
  output logic         fifo_rd_en,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic         awvalid,
  input  logic         awready,
  output logic [255:0] wdata,
  output logic [31:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready,
  output logic [1:0]   wr_frame_idx,
  output logic [1:0]   done_frame_idx,
  output logic         frame_done,
  output logic         frame_drop,
  output logic         axi_err
);

  localparam logic [31:0] c_burst_bytes = 32'(BURST_LEN * 32);
  localparam logic [8:0]  c_burst_beats = 9'(BURST_LEN);
  localparam logic [8:0]  c_last_beat   = 9'(BURST_LEN - 1);
  localparam logic [1:0]  c_last_idx    = 2'(FRAME_NUM - 1);
  localparam logic [31:0] c_last_base   = BASE_ADDR + 32'(FRAME_NUM - 1) * FRAME_BYTES;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_ADDR      = 3'd2,
    S_DATA      = 3'd3,
    S_RESP      = 3'd4
  } state_e;

  state_e      state_q;
  logic [1:0]  wr_idx_q;
  logic [1:0]  done_idx_q;
  logic [31:0] frame_base_q;
  logic [31:0] offset_q;
  logic [8:0]  beat_cnt_q;
  logic [31:0] awaddr_q;
  logic        awvalid_q;
  logic        bready_q;
  logic        frame_done_q;
  logic        frame_drop_q;
  logic        pending_q;

  logic [1:0]  wr_idx_d;
  logic [31:0] frame_base_d;
  logic [31:0] offset_d;
  logic        beat_acc;
  logic        beat_last;
  logic        restart;

  // Running frame base avoids a multiplier on the address path.
  assign wr_idx_d     = (wr_idx_q == c_last_idx) ? 2'd0 : wr_idx_q + 2'd1;
  assign frame_base_d = (wr_idx_q == c_last_idx) ? BASE_ADDR : frame_base_q + FRAME_BYTES;
  assign offset_d     = offset_q + c_burst_bytes;
  assign restart      = pending_q | frame_start;

  assign wvalid     = (state_q == S_DATA) & fifo_rd_vld;
  assign wdata      = fifo_rd_data;
  assign wstrb      = '1;
  assign wlast      = (state_q == S_DATA) && (beat_cnt_q == c_last_beat);
  assign beat_acc   = wvalid & wready;
  assign beat_last  = beat_acc & wlast;
  assign fifo_rd_en = beat_acc;

  assign awaddr         = awaddr_q;
  assign awlen          = 8'(BURST_LEN - 1);
  assign awvalid        = awvalid_q;
  assign bready         = bready_q;
  assign wr_frame_idx   = wr_idx_q;
  assign done_frame_idx = done_idx_q;
  assign frame_done     = frame_done_q;
  assign frame_drop     = frame_drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_idx_q     <= c_last_idx;
      done_idx_q   <= 2'd0;
      frame_base_q <= c_last_base;
      offset_q     <= 32'd0;
      beat_cnt_q   <= 9'd0;
      awaddr_q     <= 32'd0;
      awvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_drop_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      frame_drop_q <= 1'b0;
      if (frame_start && (state_q != S_IDLE)) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            wr_idx_q     <= wr_idx_d;
            frame_base_q <= frame_base_d;
            offset_q     <= 32'd0;
            state_q      <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (fifo_rd_cnt >= c_burst_beats) begin
            awaddr_q  <= frame_base_q + offset_q;
            awvalid_q <= 1'b1;
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (awready) begin
            awvalid_q  <= 1'b0;
            beat_cnt_q <= 9'd0;
            state_q    <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_acc) begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
          end
          if (beat_last) begin
            bready_q <= 1'b1;
            state_q  <= S_RESP;
          end
        end
        S_RESP: begin
          if (bvalid) begin
            bready_q  <= 1'b0;
            pending_q <= 1'b0;
            if (offset_d == FRAME_BYTES) begin
              done_idx_q   <= wr_idx_q;
              frame_done_q <= 1'b1;
              if (restart) begin
                wr_idx_q     <= wr_idx_d;
                frame_base_q <= frame_base_d;
                offset_q     <= 32'd0;
                state_q      <= S_WAIT_DATA;
              end else begin
                offset_q <= offset_d;
                state_q  <= S_IDLE;
              end
            end else if (restart) begin
              // Early frame_start abandons the rest of this frame.
              frame_drop_q <= 1'b1;
              wr_idx_q     <= wr_idx_d;
              frame_base_q <= frame_base_d;
              offset_q     <= 32'd0;
              state_q      <= S_WAIT_DATA;
            end else begin
              offset_q <= offset_d;
              state_q  <= S_WAIT_DATA;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef VIDEO_WR_BRESP_CHK_EN
  logic axi_err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      axi_err_q <= 1'b0;
    end else if (bvalid && bready_q && (bresp != 2'b00)) begin
      axi_err_q <= 1'b1;
    end
  end
  assign axi_err = axi_err_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^bresp;
  assign axi_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_wr_burst_ctrl.sv
`default_nettype none
// Testbench for video_wr_burst_ctrl: randomized FIFO/AXI handshakes checked
// against a frame/burst-level reference model of the write schedule.
module tb_video_wr_burst_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] FB   = 32'h0000_1000;
  localparam int          NFR  = 3;
  localparam int          BL   = 16;
  localparam logic [31:0] BB   = 32'(BL * 32);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frame_start = 1'b0;
  logic [8:0]   fifo_rd_cnt = 9'd0;
  logic         fifo_rd_vld = 1'b0;
  logic [255:0] fifo_rd_data = '0;
  logic         awready = 1'b0;
  logic         wready = 1'b0;
  logic [1:0]   bresp = 2'b00;
  logic         bvalid = 1'b0;

  logic         fifo_rd_en;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic         awvalid;
  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         bready;
  logic [1:0]   wr_frame_idx;
  logic [1:0]   done_frame_idx;
  logic         frame_done;
  logic         frame_drop;
  logic         axi_err;

  video_wr_burst_ctrl #(
    .BASE_ADDR  (BASE),
    .FRAME_BYTES(FB),
    .FRAME_NUM  (NFR),
    .BURST_LEN  (BL)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .fifo_rd_cnt   (fifo_rd_cnt),
    .fifo_rd_vld   (fifo_rd_vld),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_en    (fifo_rd_en),
    .awaddr        (awaddr),
    .awlen         (awlen),
    .awvalid       (awvalid),
    .awready       (awready),
    .wdata         (wdata),
    .wstrb         (wstrb),
    .wlast         (wlast),
    .wvalid        (wvalid),
    .wready        (wready),
    .bresp         (bresp),
    .bvalid        (bvalid),
    .bready        (bready),
    .wr_frame_idx  (wr_frame_idx),
    .done_frame_idx(done_frame_idx),
    .frame_done    (frame_done),
    .frame_drop    (frame_drop),
    .axi_err       (axi_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [255:0] pat(input int unsigned s);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = (s * 8 + k) ^ 32'h5A00_0000;
    return r;
  endfunction

  // Reference model state (frame/burst level)
  int          m_frame = NFR - 1;
  logic [31:0] m_off = 32'd0;
  bit          m_idle = 1'b1;
  bit          m_pend = 1'b0;
  int          m_done = 0;
  int          m_beats = 0;
  bit          m_in_data = 1'b0;
  bit          m_inburst = 1'b0;
  int unsigned m_wseq = 0;
  bit          exp_done = 1'b0;
  bit          exp_drop = 1'b0;
  bit          exp_err = 1'b0;
  bit          err_chk_next = 1'b0;
  int          n_done = 0;
  int          n_drop = 0;
  int          n_aw = 0;
  int          n_wlast = 0;
  bit          hs_w = 1'b0;
  bit          hs_wlast = 1'b0;
  bit          hs_b = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_frame = NFR - 1; m_off = 32'd0; m_idle = 1'b1; m_pend = 1'b0; m_done = 0;
      m_beats = 0; m_in_data = 1'b0; m_inburst = 1'b0;
      exp_done = 1'b0; exp_drop = 1'b0; exp_err = 1'b0; err_chk_next = 1'b0;
      hs_w = 1'b0; hs_wlast = 1'b0; hs_b = 1'b0;
    end else begin
      if (frame_done || exp_done) begin
        chk("frame_done", frame_done, exp_done);
        chk("done_idx", done_frame_idx, m_done);
      end
      if (frame_drop || exp_drop) begin
        chk("frame_drop", frame_drop, exp_drop);
        chk("drop_done_idx", done_frame_idx, m_done);
        chk("drop_wr_idx", wr_frame_idx, m_frame);
      end
      if (err_chk_next) chk("axi_err", axi_err, exp_err);
      if (frame_done) n_done++;
      if (frame_drop) n_drop++;
      exp_done = 1'b0; exp_drop = 1'b0; err_chk_next = 1'b0;

      hs_w     = wvalid && wready;
      hs_wlast = hs_w && wlast;
      hs_b     = bvalid && bready;

      if (m_in_data) begin
        chk("wvalid", wvalid, fifo_rd_vld);
        chk("rd_en", fifo_rd_en, fifo_rd_vld && wready);
      end
      if (awvalid) chk("aw_single", m_inburst, 1'b0);
      if (awvalid && awready) begin
        chk("awaddr", awaddr, BASE + 32'(m_frame) * FB + m_off);
        chk("awlen", awlen, BL - 1);
        chk("wr_idx", wr_frame_idx, m_frame);
        m_inburst = 1'b1; m_in_data = 1'b1; m_beats = 0; n_aw++;
      end
      if (hs_w) begin
        chk("wdata", wdata, pat(m_wseq));
        chk("wstrb", wstrb, 32'hFFFF_FFFF);
        chk("wlast", wlast, m_beats == BL - 1);
        if (wlast) n_wlast++;
        m_wseq++; m_beats++;
        if (m_beats == BL) m_in_data = 1'b0;
      end
      if (hs_b) begin
        chk("burst_beats", m_beats, BL);
`ifdef VIDEO_WR_BRESP_CHK_EN
        if (bresp != 2'b00) exp_err = 1'b1;
`endif
        err_chk_next = 1'b1;
        m_off = m_off + BB;
        if (m_off == FB) begin
          exp_done = 1'b1; m_done = m_frame;
          if (m_pend || frame_start) begin m_frame = (m_frame + 1) % NFR; m_off = 32'd0; end
          else m_idle = 1'b1;
        end else if (m_pend || frame_start) begin
          exp_drop = 1'b1; m_frame = (m_frame + 1) % NFR; m_off = 32'd0;
        end
        m_pend = 1'b0; m_inburst = 1'b0;
      end else if (frame_start) begin
        if (m_idle) begin m_idle = 1'b0; m_frame = (m_frame + 1) % NFR; m_off = 32'd0; end
        else m_pend = 1'b1;
      end
    end
  end

  // Stimulus / AXI slave / FIFO head driver
  int unsigned seq = 0;
  bit rnd = 1'b0, cnt_rnd = 1'b0, fs_req = 1'b0, fs_coinc = 1'b0, err_next = 1'b0, b_owed = 1'b0;
  int cnt_fix = 0;
  int b_dly = 0;

  task automatic step();
    @(posedge clk); #1;
    if (hs_w) seq++;
    if (hs_b) bvalid = 1'b0;
    if (hs_wlast) begin b_owed = 1'b1; b_dly = rnd ? int'($urandom_range(0, 3)) : 0; end
    frame_start = fs_req; fs_req = 1'b0;
    if (b_owed) begin
      if (b_dly == 0) begin
        bvalid = 1'b1; bresp = err_next ? 2'b10 : 2'b00; err_next = 1'b0; b_owed = 1'b0;
        if (fs_coinc && (m_off == FB - BB)) begin frame_start = 1'b1; fs_coinc = 1'b0; end
      end else b_dly--;
    end
    awready      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    wready       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    fifo_rd_vld  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    fifo_rd_data = pat(seq);
    fifo_rd_cnt  = cnt_rnd ? 9'($urandom_range(14, 40)) : 9'(cnt_fix);
  endtask

  task automatic wait_done(input int bound);
    int start = n_done;
    int k = 0;
    while ((n_done == start) && (k < bound)) begin step(); k++; end
    chk("frame_done_wait", n_done != start, 1'b1);
  endtask

  initial begin
    bit any_aw;
    int k;
    repeat (3) step();
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_drop", frame_drop, 1'b0);
    chk("rst_axi_err", axi_err, 1'b0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_awlen", awlen, BL - 1);
    chk("rst_wr_idx", wr_frame_idx, NFR - 1);
    chk("rst_done_idx", done_frame_idx, 2'd0);
    rst = 1'b0;

    cnt_fix = 200; any_aw = 1'b0;
    repeat (20) begin step(); if (awvalid) any_aw = 1'b1; end
    chk("idle_no_aw", any_aw, 1'b0);

    cnt_fix = 15; fs_req = 1'b1; step(); any_aw = 1'b0;
    repeat (10) begin step(); if (awvalid) any_aw = 1'b1; end
    chk("cnt15_no_aw", any_aw, 1'b0);
    cnt_fix = 16; step();
    chk("aw_not_early", awvalid, 1'b0);
    step();
    chk("aw_next_cycle", awvalid, 1'b1);
    cnt_fix = 200;
    wait_done(2000);
    chk("frame0_bursts", n_aw, 8);
    chk("frame0_wlast", n_wlast, 8);
    chk("frame0_done_idx", done_frame_idx, 2'd0);

    rnd = 1'b1; cnt_rnd = 1'b1;
    fs_req = 1'b1; wait_done(3000);
    chk("axi_err_clean", axi_err, 1'b0);
    err_next = 1'b1; fs_coinc = 1'b1; fs_req = 1'b1; wait_done(3000);
    chk("coinc_no_drop", n_drop, 0);
    wait_done(3000);
    chk("wrap_done_idx", done_frame_idx, 2'd0);

    fs_req = 1'b1; k = 0;
    while (!((m_off == 2 * BB) && (m_beats >= 4) && (m_beats < BL)) && (k < 3000)) begin step(); k++; end
    chk("drop_setup_wait", (m_off == 2 * BB) && (m_beats >= 4) && (m_beats < BL), 1'b1);
    fs_req = 1'b1; step(); k = 0;
    while ((n_drop == 0) && (k < 3000)) begin step(); k++; end
    chk("drop_seen", n_drop, 1);
    chk("drop_kept_done_idx", done_frame_idx, 2'd0);
    wait_done(3000);
    chk("after_drop_done_idx", done_frame_idx, 2'd2);
`ifdef VIDEO_WR_BRESP_CHK_EN
    chk("axi_err_sticky", axi_err, 1'b1);
`else
    chk("axi_err_sticky", axi_err, 1'b0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
